mat_mul_seq: RTL
================

// Module: mat_mul_seq
// PURPOSE
//  Time-multiplexed, handshaked float matrix multiply: res(IxK) = lhs(IxJ) * op(rhs).
//  Captures both operands on a valid/ready handshake and evaluates the I*K dot products
//  through LANES shared vec_dot instances, LANES outputs per cycle.
//  Holds the full result until the consumer accepts it.
//  Area/throughput-scalable successor to the fully parallel mat_mul; sits between the
//  operand buffers and the result sink.
// PARAMETERS
//  FLOAT_BIAS_PARAMS  std set    float format; propagated unchanged to every vec_dot
//  I                  4          lhs rows / res rows
//  J                  4          inner dimension (vec_dot VEC_SIZE)
//  K                  4          rhs cols / res cols
//  LANES              1          parallel vec_dot instances, 1..I*K
//  DOT_LAT            1          vec_dot pipeline depth in clk cycles for VEC_SIZE=J (0 = comb.)
// PORTS
//  clk        in   1               clock, rising edge
//  rst_n      in   1               synchronous reset, active low
//  in_valid   in   1               lhs/rhs/rhs_trans valid
//  in_ready   out  1               block can accept operands
//  lhs        in   MAT_WIDTH(I,J)  row-major, element (i,j) at MAT_SELECT(i,j,J)
//  rhs        in   MAT_WIDTH(J,K)  row-major JxK, or KxJ when rhs_trans=1
//  rhs_trans  in   1               1: rhs element (j,k) read from MAT_SELECT(k,j,J)
//  out_valid  out  1               res holds a complete product
//  out_ready  in   1               consumer accepts res
//  res        out  MAT_WIDTH(I,K)  row-major, element (i,k) at MAT_SELECT(i,k,K)
//  busy       out  1               state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE; in_ready=1; out_valid=0; busy=0; res=0.
//   Issue index and tag pipeline are cleared. Reset during any state aborts the operation.
//   No in-flight tag writes res after reset.
//  FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE. in_ready = (state==IDLE). No overlap of jobs.
//  IDLE: on in_valid&&in_ready, register lhs, rhs and rhs_trans; set n=0; go to ISSUE.
//  ISSUE: lane L computes flat index n+L -> (i,k) = ((n+L)/K, (n+L)%K).
//   Lane L is fed row i of lhs and column k of op(rhs).
//   Lanes with n+L >= I*K are masked: their tag is invalid and they never write res.
//   Each cycle n += LANES. Go to DRAIN after the cycle where n+LANES >= I*K.
//   Issue count N = ceil(I*K/LANES).
//  Tag pipe: DOT_LAT-deep shift register of {valid, base index} matched to vec_dot latency.
//   When a valid tag emerges, the lane outputs are written to res at their flat indices.
//  DRAIN: wait until the tag pipe is empty, then go to DONE.
//   DOT_LAT=0: writes happen in the issue cycle and DRAIN lasts 1 cycle.
//  DONE: out_valid=1; res is stable; in_valid is ignored.
//   On out_ready: next cycle state=IDLE, out_valid=0, in_ready=1.
//   res keeps its value until the next job overwrites its elements.
//  Latency: out_valid rises exactly N+DOT_LAT+1 cycles after the accepting edge.
//  Arithmetic: only vec_dot performs arithmetic; this block adds none.
//   No rounding or width change; each res element equals the vec_dot output bit-exactly.
//  Operands held internally: caller may change lhs/rhs the cycle after acceptance.
// TESTING (default float format binary32, e.g. 1.0=32'h3F80_0000)
//  I=J=K=2, LANES=1, lhs=[[1,2],[3,4]], rhs=[[5,6],[7,8]] -> res=[[19,22],[43,50]]; out_valid at accept+4+DOT_LAT+1.
//  Same data with rhs_trans=1 -> res=[[17,23],[39,53]].
//  I=J=K=2, LANES=3 (remainder lane) -> N=2, res=[[19,22],[43,50]]; no write from masked lane.
//  Hold out_ready=0 for 10 cycles in DONE -> res stable, in_ready=0, in_valid pulses ignored; then out_ready=1 -> in_ready=1 next cycle.
//  rst_n=0 for 1 cycle mid-ISSUE -> next cycle out_valid=0, res=0, in_ready=1; a following job gives correct res with no stale writes.
//  Default 4x4, lhs=identity, random rhs, LANES in {1,2,4,16} -> res==rhs bit-exact, latency N+DOT_LAT+1.

Source files
------------

// File: rtl/mat_mul_seq.sv
// Time-multiplexed float matrix multiply res = lhs * op(rhs) over LANES shared vec_dot cores.
// vec_dot is a combinational flush-to-zero, truncating dot product; mat_mul_seq adds its DOT_LAT stages.
module vec_dot #(
  parameter int unsigned EXP_W    = 8,
  parameter int unsigned FRAC_W   = 23,
  parameter int unsigned VEC_SIZE = 4,
  localparam int unsigned FW      = 1 + EXP_W + FRAC_W
) (
  input  logic [VEC_SIZE*FW-1:0] a,
  input  logic [VEC_SIZE*FW-1:0] b,
  output logic [FW-1:0]          y
);
  localparam int unsigned F    = FRAC_W;
  localparam int unsigned G    = 3;
  localparam int unsigned MW   = F + 1 + G;
  localparam int          BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int          EMAX = (1 << EXP_W) - 1;

  function automatic logic [FW-1:0] fp_mul(input logic [FW-1:0] x, input logic [FW-1:0] z);
    logic           s;
    logic [2*F+1:0] p;
    logic [F-1:0]   fr;
    int             e;
    s = x[FW-1] ^ z[FW-1];
    if (x[FW-2:F] == '0 || z[FW-2:F] == '0) return {s, {(FW-1){1'b0}}};
    p = {{(F+1){1'b0}}, 1'b1, x[F-1:0]} * {{(F+1){1'b0}}, 1'b1, z[F-1:0]};
    e = int'(x[FW-2:F]) + int'(z[FW-2:F]) - BIAS;
    if (p[2*F+1]) begin
      fr = p[2*F:F+1];
      e++;
    end else begin
      fr = p[2*F-1:F];
    end
    if (e <= 0) return {s, {(FW-1){1'b0}}};
    if (e >= EMAX) return {s, {EXP_W{1'b1}}, {F{1'b0}}};
    return {s, EXP_W'(e), fr};
  endfunction

  function automatic logic [FW-1:0] fp_add(input logic [FW-1:0] x0, input logic [FW-1:0] z0);
    logic [FW-1:0] x, z;
    logic [MW:0]   mx, mz, sm;
    int unsigned   d;
    int            e;
    // A zero operand returns the other one untouched, keeping x + 0 bit-exact.
    if (x0[FW-2:F] == '0) return z0;
    if (z0[FW-2:F] == '0) return x0;
    if (x0[FW-2:0] >= z0[FW-2:0]) begin
      x = x0; z = z0;
    end else begin
      x = z0; z = x0;
    end
    d  = 32'(x[FW-2:F]) - 32'(z[FW-2:F]);
    mx = {1'b0, 1'b1, x[F-1:0], {G{1'b0}}};
    mz = {1'b0, 1'b1, z[F-1:0], {G{1'b0}}};
    mz = (d > MW) ? '0 : mz >> d;
    e  = int'(x[FW-2:F]);
    sm = (x[FW-1] == z[FW-1]) ? mx + mz : mx - mz;
    if (sm == '0) return '0;
    if (sm[MW]) begin
      sm = sm >> 1;
      e++;
    end else begin
      for (int unsigned i = 0; i < MW; i++) begin
        if (!sm[MW-1]) begin
          sm = sm << 1;
          e--;
        end
      end
    end
    if (e <= 0) return {x[FW-1], {(FW-1){1'b0}}};
    if (e >= EMAX) return {x[FW-1], {EXP_W{1'b1}}, {F{1'b0}}};
    return {x[FW-1], EXP_W'(e), sm[MW-2:G]};
  endfunction

  always_comb begin
    y = fp_mul(a[0 +: FW], b[0 +: FW]);
    for (int unsigned j = 1; j < VEC_SIZE; j++)
      y = fp_add(y, fp_mul(a[j*FW +: FW], b[j*FW +: FW]));
  end
endmodule

module mat_mul_seq #(
  parameter int unsigned EXP_W   = 8,
  parameter int unsigned FRAC_W  = 23,
  parameter int unsigned I       = 4,
  parameter int unsigned J       = 4,
  parameter int unsigned K       = 4,
  parameter int unsigned LANES   = 1,
  parameter int unsigned DOT_LAT = 1,
  localparam int unsigned FW     = 1 + EXP_W + FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [I*J*FW-1:0] lhs,
  input  logic [J*K*FW-1:0] rhs,
  input  logic              rhs_trans,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [I*K*FW-1:0] res,
  output logic              busy
);
  localparam int unsigned NE = I * K;
  localparam int unsigned NW = $clog2(NE + LANES) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
  state_t state, state_nx;

  logic [NW-1:0]     n;
  logic [I*J*FW-1:0] lhs_r;
  logic [J*K*FW-1:0] rhs_r;
  logic              trans_r;
  logic              issue, last_issue, pipe_busy, wr_v;
  logic [NW-1:0]     wr_n;
  logic [J*FW-1:0]   lane_a [LANES];
  logic [J*FW-1:0]   lane_b [LANES];
  logic [FW-1:0]     lane_y [LANES];
  logic [FW-1:0]     wr_y   [LANES];

  assign last_issue = (32'(n) + LANES) >= NE;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    issue     = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        issue = 1'b1;
        if (last_issue) state_nx = S_DRAIN;
      end
      S_DRAIN: if (!pipe_busy) state_nx = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n       <= '0;
      lhs_r   <= '0;
      rhs_r   <= '0;
      trans_r <= 1'b0;
    end else if (state == S_IDLE && in_valid) begin
      n       <= '0;
      lhs_r   <= lhs;
      rhs_r   <= rhs;
      trans_r <= rhs_trans;
    end else if (issue) begin
      n <= n + NW'(LANES);
    end
  end

  // Masked lanes (index past I*K) read element 0; their results are never written.
  always_comb begin : lane_mux
    int unsigned idx, ri, ck;
    idx = 0; ri = 0; ck = 0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_a[l] = '0;
      lane_b[l] = '0;
      idx = 32'(n) + l;
      ri  = 0;
      ck  = 0;
      if (idx < NE) begin
        ri = idx / K;
        ck = idx % K;
      end
      for (int unsigned j = 0; j < J; j++) begin
        lane_a[l][j*FW +: FW] = lhs_r[(ri*J + j)*FW +: FW];
        lane_b[l][j*FW +: FW] = trans_r ? rhs_r[(ck*J + j)*FW +: FW]
                                        : rhs_r[(j*K + ck)*FW +: FW];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    vec_dot #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .VEC_SIZE(J)) u_dot (
      .a(lane_a[l]),
      .b(lane_b[l]),
      .y(lane_y[l])
    );
  end

  if (DOT_LAT == 0) begin : g_tag_comb
    assign wr_v      = issue;
    assign wr_n      = n;
    assign pipe_busy = 1'b0;
    always_comb begin
      for (int unsigned l = 0; l < LANES; l++) wr_y[l] = lane_y[l];
    end
  end else begin : g_tag_pipe
    logic          tag_v [DOT_LAT];
    logic [NW-1:0] tag_n [DOT_LAT];
    logic [FW-1:0] dpipe [LANES][DOT_LAT];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int unsigned s = 0; s < DOT_LAT; s++) begin
          tag_v[s] <= 1'b0;
          tag_n[s] <= '0;
        end
      end else begin
        tag_v[0] <= issue;
        tag_n[0] <= n;
        for (int unsigned s = 1; s < DOT_LAT; s++) begin
          tag_v[s] <= tag_v[s-1];
          tag_n[s] <= tag_n[s-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        dpipe[l][0] <= lane_y[l];
        for (int unsigned s = 1; s < DOT_LAT; s++) dpipe[l][s] <= dpipe[l][s-1];
      end
    end

    always_comb begin
      pipe_busy = 1'b0;
      for (int unsigned s = 0; s < DOT_LAT; s++) pipe_busy = pipe_busy | tag_v[s];
      for (int unsigned l = 0; l < LANES; l++) wr_y[l] = dpipe[l][DOT_LAT-1];
    end

    assign wr_v = tag_v[DOT_LAT-1];
    assign wr_n = tag_n[DOT_LAT-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res <= '0;
    end else if (wr_v) begin
      for (int unsigned l = 0; l < LANES; l++)
        if (32'(wr_n) + l < NE) res[(32'(wr_n) + l)*FW +: FW] <= wr_y[l];
    end
  end
endmodule
